// File: rtl/slot_sched_pkg.sv
// Shared types and constants for the slotmaker configuration scheduler.
package slot_sched_pkg;

  localparam int unsigned SLOT_W = 3;
  localparam int unsigned CARD_W = 8;

  // Card ids understood by the slotmaker
  localparam logic [CARD_W-1:0] CARD_EMPTY   = 8'h00;
  localparam logic [CARD_W-1:0] CARD_INVALID = 8'hFF;

  typedef enum logic [2:0] {
    StBoot,
    StBootEnd,
    StIdle,
    StWrite,
    StWait,
    StCheck
  } sched_state_e;

  // Pick the boot card for one slot out of a packed map (byte n = slot n)
  function automatic logic [CARD_W-1:0] map_card(input logic [63:0]       map,
                                                 input logic [SLOT_W-1:0] idx);
    return map[idx*CARD_W +: CARD_W];
  endfunction

endpackage

// File: rtl/slot_sched_rr_arb.sv
// Two-way round-robin arbiter: on contention the port that did not win last time wins.
module slot_sched_rr_arb (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       grant_o,
  output logic       valid_o
);

  // Grant selection
  always_comb begin
    valid_o = |req_i;
    grant_o = 1'b0;
    case (req_i)
      2'b01:   grant_o = 1'b0;
      2'b10:   grant_o = 1'b1;
      2'b11:   grant_o = ~last_i;
      default: grant_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/slot_config_scheduler.sv
// Sequences all writes into the slotmaker config port: boot map load, then arbitrated,
// read-back-verified writes from two requesters.
module slot_config_scheduler
  import slot_sched_pkg::*;
#(
  parameter int unsigned NUM_SLOTS   = 8,
  parameter logic [63:0] DEFAULT_MAP = 64'h0000_0000_0000_0000,
  parameter int unsigned READ_LAT    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  input  logic [5:0]        req_slot,
  input  logic [15:0]       req_card,
  input  logic [1:0]        req_reconfig,
  output logic [1:0]        req_ack,
  output logic              req_err,
  output logic              boot_done,
  output logic [SLOT_W-1:0] cfg_slot,
  output logic [CARD_W-1:0] cfg_card,
  output logic              cfg_wr,
  output logic              cfg_reconfig,
  input  logic [CARD_W-1:0] cfg_card_rd
);

  localparam logic [SLOT_W-1:0] LastIdx = SLOT_W'(NUM_SLOTS - 1);
  localparam logic [1:0]        LatCnt  = 2'(READ_LAT);

  sched_state_e      state_q, state_d;
  logic [SLOT_W-1:0] idx_q, idx_d;
  logic              rr_last_q, rr_last_d;
  logic              grant_q, grant_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [CARD_W-1:0] card_q, card_d;
  logic              wr_q, wr_d;
  logic              rc_q, rc_d;
  logic [1:0]        ack_q, ack_d;
  logic              err_q, err_d;
  logic              done_q, done_d;

  logic arb_grant;
  logic arb_valid;

  slot_sched_rr_arb u_arb (
    .req_i   (req_valid),
    .last_i  (rr_last_q),
    .grant_o (arb_grant),
    .valid_o (arb_valid)
  );

  // Next-state and registered-output logic. The cfg_* and ack registers are loaded on the
  // edge that enters a state, so each output lines up with the state it belongs to.
  // slot_q/card_q double as the latched request for the read-back compare.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rr_last_d = rr_last_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    slot_d    = slot_q;
    card_d    = card_q;
    wr_d      = 1'b0;
    rc_d      = 1'b0;
    ack_d     = 2'b00;
    err_d     = 1'b0;
    done_d    = done_q;

    unique case (state_q)
      StBoot: begin
        wr_d   = 1'b1;
        slot_d = idx_q;
        card_d = map_card(DEFAULT_MAP, idx_q);
        idx_d  = idx_q + SLOT_W'(1);
        if (idx_q == LastIdx) begin
          rc_d    = 1'b1;
          state_d = StBootEnd;
        end
      end
      StBootEnd: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      StIdle: begin
        if (arb_valid) begin
          grant_d   = arb_grant;
          rr_last_d = arb_grant;
          slot_d    = arb_grant ? req_slot[5:3]  : req_slot[2:0];
          card_d    = arb_grant ? req_card[15:8] : req_card[7:0];
          rc_d      = req_reconfig[arb_grant];
          wr_d      = 1'b1;
          state_d   = StWrite;
        end
      end
      StWrite: begin
        cnt_d   = 2'd0;
        state_d = StWait;
      end
      StWait: begin
        // Read-back is sampled on the edge into CHECK so the ack is visible during CHECK
        // and the requester drops its request before the next IDLE.
        if (cnt_q == LatCnt) begin
          ack_d   = grant_q ? 2'b10 : 2'b01;
          err_d   = (cfg_card_rd != card_q);
          state_d = StCheck;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      StCheck: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StBoot;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StBoot;
      idx_q     <= '0;
      rr_last_q <= 1'b1;
      grant_q   <= 1'b0;
      cnt_q     <= 2'd0;
      slot_q    <= '0;
      card_q    <= CARD_EMPTY;
      wr_q      <= 1'b0;
      rc_q      <= 1'b0;
      ack_q     <= 2'b00;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rr_last_q <= rr_last_d;
      grant_q   <= grant_d;
      cnt_q     <= cnt_d;
      slot_q    <= slot_d;
      card_q    <= card_d;
      wr_q      <= wr_d;
      rc_q      <= rc_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      done_q    <= done_d;
    end
  end

  assign cfg_slot     = slot_q;
  assign cfg_card     = card_q;
  assign cfg_wr       = wr_q;
  assign cfg_reconfig = rc_q;
  assign req_ack      = ack_q;
  assign req_err      = err_q;
  assign boot_done    = done_q;

endmodule

// File: tb/tb_slot_config_scheduler.sv
// Self-checking bench: slotmaker stand-in, transaction-level expectation model, directed stimulus.
module tb_slot_config_scheduler;

  localparam logic [63:0] MAP        = 64'h0807060504030201;
  localparam int          NS         = 8;
  localparam int          RL         = 1;
  localparam logic [2:0]  FAULT_SLOT = 3'd2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  req_valid;
  logic [5:0]  req_slot;
  logic [15:0] req_card;
  logic [1:0]  req_reconfig;
  logic [1:0]  req_ack;
  logic        req_err;
  logic        boot_done;
  logic [2:0]  cfg_slot;
  logic [7:0]  cfg_card;
  logic        cfg_wr;
  logic        cfg_reconfig;
  logic [7:0]  cfg_card_rd;

  always #5 clk = ~clk;

  slot_config_scheduler #(
    .NUM_SLOTS   (NS),
    .DEFAULT_MAP (MAP),
    .READ_LAT    (RL)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_slot     (req_slot),
    .req_card     (req_card),
    .req_reconfig (req_reconfig),
    .req_ack      (req_ack),
    .req_err      (req_err),
    .boot_done    (boot_done),
    .cfg_slot     (cfg_slot),
    .cfg_card     (cfg_card),
    .cfg_wr       (cfg_wr),
    .cfg_reconfig (cfg_reconfig),
    .cfg_card_rd  (cfg_card_rd)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slotmaker stand-in: write-through memory, card_o delayed RL cycles, slot 2 reads as FF
  logic [7:0] sm_mem [NS];
  logic [7:0] rd_pipe [RL];
  logic [7:0] rd_now;

  always_comb begin
    rd_now = cfg_wr ? cfg_card : sm_mem[cfg_slot];
    if (cfg_slot == FAULT_SLOT) rd_now = 8'hFF;
  end

  always @(posedge clk) begin
    if (cfg_wr) sm_mem[cfg_slot] <= cfg_card;
    rd_pipe[0] <= rd_now;
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  assign cfg_card_rd = rd_pipe[RL-1];

  // Expectation model: cycle n is the interval after the n-th edge since reset release.
  // Boot writes occupy cycles 1..NS, boot_done from NS+1. A grant taken at edge s writes in
  // cycle s, acks in cycle s+RL+2, and the next grant can be taken at edge s+RL+4.
  logic [63:0] map_v = MAP;
  logic        e_wr = 1'b0, e_rc = 1'b0, e_boot = 1'b0, e_err = 1'b0;
  logic [1:0]  e_ack = 2'b00;
  logic [2:0]  e_slot = 3'd0;
  logic [7:0]  e_card = 8'd0;
  int          ack_at = -1;
  int          next_free = NS + 2;
  logic [1:0]  ack_port_v = 2'b00;
  logic        ack_err_v = 1'b0;
  logic        last = 1'b1;
  int          m_p;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc = 0; e_wr = 0; e_rc = 0; e_boot = 0; e_err = 0; e_ack = 0;
      e_slot = 0; e_card = 0; ack_at = -1; next_free = NS + 2; last = 1'b1;
    end else begin
      cyc++;
      e_wr = 0; e_rc = 0; e_ack = 0; e_err = 0;
      if (cyc <= NS) begin
        e_wr   = 1'b1;
        e_slot = 3'(cyc - 1);
        e_card = map_v[(cyc-1)*8 +: 8];
        e_rc   = (cyc == NS);
      end
      if (cyc == NS + 1) e_boot = 1'b1;
      if (cyc == ack_at) begin
        e_ack = ack_port_v;
        e_err = ack_err_v;
      end
      if (cyc >= next_free && req_valid != 2'b00) begin
        if (req_valid == 2'b11) m_p = last ? 0 : 1;
        else                    m_p = req_valid[1] ? 1 : 0;
        e_wr       = 1'b1;
        e_slot     = (m_p == 1) ? req_slot[5:3] : req_slot[2:0];
        e_card     = (m_p == 1) ? req_card[15:8] : req_card[7:0];
        e_rc       = req_reconfig[m_p];
        ack_at     = cyc + RL + 2;
        next_free  = cyc + RL + 4;
        last       = (m_p == 1);
        ack_port_v = (m_p == 1) ? 2'b10 : 2'b01;
        ack_err_v  = (((e_slot == FAULT_SLOT) ? 8'hFF : e_card) != e_card);
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("cfg_wr", 32'(cfg_wr), 32'(e_wr));
    chk("cfg_reconfig", 32'(cfg_reconfig), 32'(e_rc));
    chk("req_ack", 32'(req_ack), 32'(e_ack));
    chk("boot_done", 32'(boot_done), 32'(e_boot));
    if (e_wr || reset) begin
      chk("cfg_slot", 32'(cfg_slot), 32'(e_slot));
      chk("cfg_card", 32'(cfg_card), 32'(e_card));
    end
    if (e_ack != 2'b00) chk("req_err", 32'(req_err), 32'(e_err));
  end

  task automatic wait_cyc(input int n);
    int guard = 0;
    while (cyc < n && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) chk("wait_bound", 32'(cyc), 32'(n));
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Directed stimulus with hand-computed literal checks
  initial begin
    for (int i = 0; i < NS; i++) sm_mem[i] = 8'h00;
    req_valid = 2'b00; req_slot = '0; req_card = '0; req_reconfig = 2'b00;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_wr", 32'(cfg_wr), 32'd0);
    chk("rst_ack", 32'(req_ack), 32'd0);
    chk("rst_done", 32'(boot_done), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Boot, with both requesters raised mid-boot
    wait_cyc(1);
    chk("boot0_slot", 32'(cfg_slot), 32'd0);
    chk("boot0_card", 32'(cfg_card), 32'h01);
    wait_cyc(3);
    req_valid = 2'b11; req_slot = {3'd6, 3'd3}; req_card = {8'h33, 8'h05};
    wait_cyc(8);
    chk("boot7_slot", 32'(cfg_slot), 32'd7);
    chk("boot7_card", 32'(cfg_card), 32'h08);
    chk("boot7_rc", 32'(cfg_reconfig), 32'd1);
    wait_cyc(9);
    chk("boot_done9", 32'(boot_done), 32'd1);
    chk("boot_wr9", 32'(cfg_wr), 32'd0);

    // Contention held continuously: grants 0,1,0,1
    wait_cyc(10);
    chk("p0_wr", 32'(cfg_wr), 32'd1);
    chk("p0_slot", 32'(cfg_slot), 32'd3);
    chk("p0_card", 32'(cfg_card), 32'h05);
    wait_cyc(13);
    chk("p0_ack", 32'(req_ack), 32'b01);
    chk("p0_err", 32'(req_err), 32'd0);
    wait_cyc(15);
    chk("p1_slot", 32'(cfg_slot), 32'd6);
    chk("p1_card", 32'(cfg_card), 32'h33);
    wait_cyc(18);
    chk("p1_ack", 32'(req_ack), 32'b10);
    wait_cyc(23);
    chk("p0_ack2", 32'(req_ack), 32'b01);
    wait_cyc(28);
    chk("p1_ack2", 32'(req_ack), 32'b10);
    req_valid = 2'b00;

    // Read-back mismatch on port 1
    wait_cyc(30);
    req_valid = 2'b10; req_slot = {3'd2, 3'd0}; req_card = {8'h02, 8'h00};
    wait_cyc(31);
    chk("mm_slot", 32'(cfg_slot), 32'd2);
    wait_cyc(34);
    chk("mm_ack", 32'(req_ack), 32'b10);
    chk("mm_err", 32'(req_err), 32'd1);
    req_valid = 2'b00;

    // Reconfig with the write
    wait_cyc(36);
    req_valid = 2'b01; req_slot = {3'd0, 3'd5}; req_card = {8'h00, 8'h44}; req_reconfig = 2'b01;
    wait_cyc(37);
    chk("rc_wr", 32'(cfg_wr), 32'd1);
    chk("rc_rc", 32'(cfg_reconfig), 32'd1);
    chk("rc_slot", 32'(cfg_slot), 32'd5);
    wait_cyc(38);
    chk("rc_wr_off", 32'(cfg_wr), 32'd0);
    chk("rc_rc_off", 32'(cfg_reconfig), 32'd0);
    wait_cyc(40);
    chk("rc_ack", 32'(req_ack), 32'b01);
    req_valid = 2'b00; req_reconfig = 2'b00;

    // Reset during WAIT
    wait_cyc(42);
    req_valid = 2'b10; req_slot = {3'd1, 3'd0}; req_card = {8'h55, 8'h00};
    wait_cyc(44);
    chk("wait_wr", 32'(cfg_wr), 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_slot", 32'(cfg_slot), 32'd0);
    chk("mid_rst_card", 32'(cfg_card), 32'd0);
    chk("mid_rst_done", 32'(boot_done), 32'd0);
    chk("mid_rst_ack", 32'(req_ack), 32'd0);
    req_valid = 2'b00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_cyc(8);
    chk("reboot7_rc", 32'(cfg_reconfig), 32'd1);
    chk("reboot7_done", 32'(boot_done), 32'd0);
    wait_cyc(9);
    chk("reboot_done", 32'(boot_done), 32'd1);
    wait_cyc(14);
    chk("no_stale_ack", 32'(req_ack), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
